// File: rtl/jtaguart_tx_arbiter.sv
// Round-robin arbiter that shares one JTAG UART transmit byte stream among NREQ
// producers, holding each grant until end of line, a burst limit or an idle timeout.
module jtaguart_tx_arbiter #(
  parameter int         NREQ         = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] EOL          = 8'h0A,
  localparam int        IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] pointer;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic [7:0]     burst_cnt;
  logic [7:0]     idle_cnt;
  logic [7:0]     burst_next;
  logic [7:0]     idle_next;
  logic [7:0]     req_bytes [NREQ];
  logic [7:0]     acc_data;
  logic           gnt_req_valid;
  logic           stage_free;
  logic           accept;
  logic           release_now;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  assign stage_free    = !tx_valid || tx_ready;
  assign gnt_req_valid = req_valid[grant_id];
  assign acc_data      = req_bytes[grant_id];
  assign accept        = (state == LOCKED) && gnt_req_valid && stage_free;
  assign burst_next    = burst_cnt + 8'd1;
  assign idle_next     = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

  // Backpressure with the requester still valid neither accepts nor ages the grant.
  assign release_now = (state == LOCKED) &&
                       (accept ? ((acc_data == EOL) || (burst_next == 8'(MAX_BURST)))
                               : (!gnt_req_valid && (idle_next == 8'(IDLE_TIMEOUT))));

  // Descending scan so the candidate closest to the pointer is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = pointer;
    cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(pointer) + k) % NREQ);
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)       state_next = LOCKED;
      LOCKED:  if (release_now) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_valid = (state == LOCKED);
    req_ready   = '0;
    for (int g = 0; g < NREQ; g++) begin
      req_ready[g] = (state == LOCKED) && (grant_id == IDW'(g)) && stage_free;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_id  <= '0;
      pointer   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant_id  <= winner;
        burst_cnt <= '0;
        idle_cnt  <= '0;
      end
    end else begin
      if (accept) begin
        burst_cnt <= burst_next;
        idle_cnt  <= '0;
      end else if (!gnt_req_valid) begin
        idle_cnt  <= idle_next;
      end
      if (release_now) begin
        pointer <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Single-entry output register; refilling while draining keeps 1 byte/cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (accept) begin
      tx_valid <= 1'b1;
      tx_data  <= acc_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtaguart_tx_arbiter.sv
// Self-checking bench for jtaguart_tx_arbiter: a cycle-accurate vector table plus
// scoreboarded multi-cycle scenarios (bursts, idle timeout, backpressure, reset).
module tb_jtaguart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        grant_valid;
  logic [0:0]  grant_id;

  jtaguart_tx_arbiter #(
    .NREQ(2), .MAX_BURST(64), .IDLE_TIMEOUT(16), .EOL(8'h0A)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       txr;
    logic       gv;
    logic       gid;
    logic [1:0] rr;
    logic       tv;
    logic [7:0] td;
  } vec_t;

  vec_t       vecs [13];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         first0, last0, first1, last1;
  int         fire1_q [$];
  logic [7:0] src0 [$];
  logic [7:0] src1 [$];
  logic [7:0] exp_q [$];
  logic       en0, en1, sb_on;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic drive_src();
    req_valid[0]  = en0 && (src0.size() > 0);
    req_valid[1]  = en1 && (src1.size() > 0);
    req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
    req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  // One clock: observe handshakes mid-cycle, then retire accepted source bytes.
  task automatic tick();
    logic f0, f1;
    @(negedge clock);
    f0 = req_valid[0] && req_ready[0];
    f1 = req_valid[1] && req_ready[1];
    if (sb_on && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL tx_extra: got %02h, expected no byte", tx_data);
      end else begin
        checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (f0) begin
      if (first0 < 0) first0 = cyc;
      last0 = cyc;
    end
    if (f1) begin
      if (first1 < 0) first1 = cyc;
      last1 = cyc;
      fire1_q.push_back(cyc);
    end
    @(posedge clock); #1;
    cyc++;
    if (f0 && src0.size() > 0) src0.delete(0);
    if (f1 && src1.size() > 0) src1.delete(0);
    drive_src();
  endtask

  task automatic applyReset();
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; sb_on = 1'b1;
    src0.delete(); src1.delete(); exp_q.delete(); fire1_q.delete();
    req_valid = '0; req_data = '0; tx_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 0);
    checkOutput("rst_grant_valid", {31'd0, grant_valid}, 0);
    checkOutput("rst_grant_id", {31'd0, grant_id}, 0);
    checkOutput("rst_req_ready", {30'd0, req_ready}, 0);
    reset = 1'b0;
    first0 = -1; last0 = -1; first1 = -1; last1 = -1; cyc = 0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL %s_timeout: %0d bytes still pending, expected 0", name, exp_q.size());
    end
    repeat (4) tick();
  endtask

  task automatic applyStimulus(input int i);
    req_valid      = vecs[i].rv;
    req_data[7:0]  = vecs[i].d0;
    req_data[15:8] = vecs[i].d1;
    tx_ready       = vecs[i].txr;
    @(negedge clock);
    checkOutput($sformatf("v%0d_grant_valid", i), {31'd0, grant_valid}, {31'd0, vecs[i].gv});
    checkOutput($sformatf("v%0d_grant_id", i), {31'd0, grant_id}, {31'd0, vecs[i].gid});
    checkOutput($sformatf("v%0d_req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].rr});
    checkOutput($sformatf("v%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].tv});
    if (vecs[i].tv)
      checkOutput($sformatf("v%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].td});
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                rv     d0     d1    txr  gv  gid  rr     tv  td
    vecs[0]  = '{2'b01, 8'h68, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00};
    vecs[1]  = '{2'b01, 8'h68, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00};
    vecs[2]  = '{2'b01, 8'h69, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h68};
    vecs[3]  = '{2'b01, 8'h0A, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h69};
    vecs[4]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'h0A};
    vecs[5]  = '{2'b11, 8'h41, 8'h42, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00};
    vecs[6]  = '{2'b11, 8'h41, 8'h42, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00};
    vecs[7]  = '{2'b11, 8'h41, 8'h0A, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'h42};
    vecs[8]  = '{2'b01, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h0A};
    vecs[9]  = '{2'b01, 8'h41, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00};
    vecs[10] = '{2'b01, 8'h0A, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h41};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'h0A};
    vecs[12] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00};

    applyReset();
    for (int i = 0; i < 13; i++) applyStimulus(i);

    // Two simultaneous "ab\n" lines: req0 first, one IDLE cycle, then req1.
    applyReset();
    en0 = 1'b1; en1 = 1'b1;
    foreach (src0[i]) src0.delete(i);
    src0.push_back(8'h61); src0.push_back(8'h62); src0.push_back(8'h0A);
    src1.push_back(8'h61); src1.push_back(8'h62); src1.push_back(8'h0A);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h0A);
    drive_src();
    drain(100, "two_lines");
    checkOutput("two_lines_req0_first", {31'd0, (first0 >= 0) && (first0 < first1)}, 1);
    checkOutput("two_lines_gap", first1, last0 + 2);

    // Burst limit: req1 streams 100 bytes without EOL while req0 waits.
    applyReset();
    en1 = 1'b1;
    for (int i = 0; i < 100; i++) src1.push_back(8'(8'h20 + i));
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(8'h20 + i));
    drive_src();
    tick();
    en0 = 1'b1;
    src0.push_back(8'h5A); src0.push_back(8'h0A);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h0A);
    for (int i = 64; i < 100; i++) exp_q.push_back(8'(8'h20 + i));
    drive_src();
    drain(400, "burst");
    checkOutput("burst_req1_count", fire1_q.size(), 100);
    if (fire1_q.size() == 100) begin
      checkOutput("burst_req0_after_64", first0, fire1_q[63] + 2);
      checkOutput("burst_req1_regrant", fire1_q[64], last0 + 2);
    end

    // Idle timeout: req0 goes quiet after one byte while req1 is pending.
    applyReset();
    en0 = 1'b1; en1 = 1'b1;
    src0.push_back(8'h70);
    src1.push_back(8'h71); src1.push_back(8'h0A);
    exp_q.push_back(8'h70); exp_q.push_back(8'h71); exp_q.push_back(8'h0A);
    drive_src();
    tick();
    checkOutput("idle_first_gv", {31'd0, grant_valid}, 1);
    checkOutput("idle_first_gid", {31'd0, grant_id}, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("idle_hold_%0d", i), {31'd0, grant_valid}, 1);
    end
    tick();
    checkOutput("idle_release_gv", {31'd0, grant_valid}, 0);
    tick();
    checkOutput("idle_regrant_gv", {31'd0, grant_valid}, 1);
    checkOutput("idle_regrant_gid", {31'd0, grant_id}, 1);
    drain(100, "idle");

    // Backpressure: tx_ready low for 30 cycles with a byte in the output stage.
    applyReset();
    en0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src0.push_back(8'(8'h30 + i));
      exp_q.push_back(8'(8'h30 + i));
    end
    src0.push_back(8'h0A); exp_q.push_back(8'h0A);
    drive_src();
    repeat (3) tick();
    checkOutput("bp_start_tv", {31'd0, tx_valid}, 1);
    checkOutput("bp_start_td", {24'd0, tx_data}, 32'h31);
    tx_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput($sformatf("bp_tv_%0d", i), {31'd0, tx_valid}, 1);
      checkOutput($sformatf("bp_td_%0d", i), {24'd0, tx_data}, 32'h31);
      checkOutput($sformatf("bp_rr_%0d", i), {30'd0, req_ready}, 0);
      checkOutput($sformatf("bp_gv_%0d", i), {31'd0, grant_valid}, 1);
    end
    tx_ready = 1'b1;
    drain(100, "backpressure");

    // Reset mid-line discards the staged byte and restarts priority at req0.
    applyReset();
    en0 = 1'b1;
    src0.push_back(8'h50); src0.push_back(8'h51); src0.push_back(8'h52); src0.push_back(8'h0A);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    drive_src();
    repeat (3) tick();
    checkOutput("midrst_pre_tv", {31'd0, tx_valid}, 1);
    sb_on = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("midrst_tv", {31'd0, tx_valid}, 0);
    checkOutput("midrst_gv", {31'd0, grant_valid}, 0);
    checkOutput("midrst_gid", {31'd0, grant_id}, 0);
    reset = 1'b0;
    src0.delete(); src1.delete(); exp_q.delete();
    en1 = 1'b1;
    src0.push_back(8'h58); src0.push_back(8'h0A);
    src1.push_back(8'h68); src1.push_back(8'h0A);
    exp_q.push_back(8'h58); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h68); exp_q.push_back(8'h0A);
    sb_on = 1'b1;
    drive_src();
    tick();
    checkOutput("midrst_winner_gv", {31'd0, grant_valid}, 1);
    checkOutput("midrst_winner_gid", {31'd0, grant_id}, 0);
    drain(100, "midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
